// File: rtl/vector_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vector_lane_sequencer
// Description : Execute-stage front end for the vector lanes. Accepts one
//               decoded vector instruction (fu type, vl, vstart), walks the
//               element range in groups of NUM_LANES, holds while the lanes
//               are busy and reports completion or the first exception.
//               Optional performance counters: define VSEQ_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_lane_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int MAXVL     = 128,
    parameter int FU_W      = 3,
    parameter int FU_IDLE   = 0
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       inst_valid,
    output logic                       inst_ready,
    input  logic [FU_W-1:0]            inst_fu_type,
    input  logic [$clog2(MAXVL):0]     inst_vl,
    input  logic [$clog2(MAXVL)-1:0]   inst_vstart,
    input  logic                       flush,
    input  logic                       lane_busy,
    input  logic                       lane_exception,
    output logic [FU_W-1:0]            fu_type_out,
    output logic                       issue_valid,
    output logic [$clog2(MAXVL)-1:0]   elem_idx,
    output logic [NUM_LANES-1:0]       lane_en,
    output logic                       last_group,
    output logic                       done,
    output logic                       exc_out,
    output logic [$clog2(MAXVL)-1:0]   exc_idx
`ifdef VSEQ_PERF_CNT_EN
    ,
    output logic [31:0]                perf_groups,
    output logic [31:0]                perf_stalls
`endif
);

    localparam int IDX_W = $clog2(MAXVL);
    localparam int VL_W  = IDX_W + 1;
    // Two extra bits so elem_idx + lane offset can never wrap.
    localparam int EXT_W = IDX_W + 2;
    localparam logic [FU_W-1:0] FU_IDLE_CODE = FU_W'(FU_IDLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [VL_W-1:0]        vl_q, vl_d;
    logic [IDX_W-1:0]       elem_idx_q, elem_idx_d;
    logic                   exc_flag_q, exc_flag_d;
    logic [IDX_W-1:0]       exc_idx_q, exc_idx_d;
    logic                   inst_ready_q, inst_ready_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [FU_W-1:0]        fu_type_out_q, fu_type_out_d;
    logic [NUM_LANES-1:0]   lane_en_q, lane_en_d;
    logic                   last_group_q, last_group_d;
    logic                   done_q, done_d;
    logic                   exc_out_q, exc_out_d;
    logic                   finish;
    logic [IDX_W-1:0]       next_idx;

    // Lane i is active when its element lies below vl.
    function automatic logic [NUM_LANES-1:0] lanes_active(input logic [IDX_W-1:0] idx,
                                                          input logic [VL_W-1:0]  vl);
        logic [NUM_LANES-1:0] en;
        en = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            en[i] = (EXT_W'(idx) + EXT_W'(i)) < EXT_W'(vl);
        end
        return en;
    endfunction

    // The group starting at idx covers the tail of the vector.
    function automatic logic is_last(input logic [IDX_W-1:0] idx,
                                     input logic [VL_W-1:0]  vl);
        return (EXT_W'(idx) + EXT_W'(NUM_LANES)) >= EXT_W'(vl);
    endfunction

    // Next-state and next-output computation; outputs are all registered.
    always_comb begin
        state_d       = state_q;
        vl_d          = vl_q;
        elem_idx_d    = elem_idx_q;
        exc_flag_d    = exc_flag_q;
        exc_idx_d     = exc_idx_q;
        inst_ready_d  = inst_ready_q;
        issue_valid_d = issue_valid_q;
        fu_type_out_d = fu_type_out_q;
        lane_en_d     = lane_en_q;
        last_group_d  = last_group_q;
        done_d        = 1'b0;
        exc_out_d     = 1'b0;
        finish        = 1'b0;
        next_idx      = elem_idx_q + IDX_W'(NUM_LANES);

        case (state_q)
            S_IDLE: begin
                if (inst_valid) begin
                    vl_d = inst_vl;
                    if ((inst_vl == '0) || (VL_W'(inst_vstart) >= inst_vl)) begin
                        // Empty range: complete without issuing any group.
                        finish = 1'b1;
                    end else begin
                        state_d       = S_RUN;
                        inst_ready_d  = 1'b0;
                        issue_valid_d = 1'b1;
                        fu_type_out_d = inst_fu_type;
                        elem_idx_d    = inst_vstart;
                        lane_en_d     = lanes_active(inst_vstart, inst_vl);
                        last_group_d  = is_last(inst_vstart, inst_vl);
                    end
                end
            end
            S_RUN: begin
                // While busy every output holds; lanes key off fu_type edges.
                if (!lane_busy) begin
                    if (lane_exception) begin
                        exc_idx_d  = elem_idx_q;
                        exc_flag_d = 1'b1;
                        finish     = 1'b1;
                    end else if (last_group_q) begin
                        finish = 1'b1;
                    end else begin
                        elem_idx_d   = next_idx;
                        lane_en_d    = lanes_active(next_idx, vl_q);
                        last_group_d = is_last(next_idx, vl_q);
                    end
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                inst_ready_d = 1'b1;
                exc_flag_d   = 1'b0;
                elem_idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d       = S_DONE;
            inst_ready_d  = 1'b0;
            issue_valid_d = 1'b0;
            fu_type_out_d = FU_IDLE_CODE;
            lane_en_d     = '0;
            last_group_d  = 1'b0;
            done_d        = 1'b1;
            exc_out_d     = exc_flag_d;
        end

        // Flush wins over everything else; the last exception index survives.
        if (flush) begin
            state_d       = S_IDLE;
            inst_ready_d  = 1'b1;
            issue_valid_d = 1'b0;
            fu_type_out_d = FU_IDLE_CODE;
            lane_en_d     = '0;
            last_group_d  = 1'b0;
            done_d        = 1'b0;
            exc_out_d     = 1'b0;
            exc_flag_d    = 1'b0;
            elem_idx_d    = '0;
            exc_idx_d     = exc_idx_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            vl_q          <= '0;
            elem_idx_q    <= '0;
            exc_flag_q    <= 1'b0;
            exc_idx_q     <= '0;
            inst_ready_q  <= 1'b1;
            issue_valid_q <= 1'b0;
            fu_type_out_q <= FU_IDLE_CODE;
            lane_en_q     <= '0;
            last_group_q  <= 1'b0;
            done_q        <= 1'b0;
            exc_out_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vl_q          <= vl_d;
            elem_idx_q    <= elem_idx_d;
            exc_flag_q    <= exc_flag_d;
            exc_idx_q     <= exc_idx_d;
            inst_ready_q  <= inst_ready_d;
            issue_valid_q <= issue_valid_d;
            fu_type_out_q <= fu_type_out_d;
            lane_en_q     <= lane_en_d;
            last_group_q  <= last_group_d;
            done_q        <= done_d;
            exc_out_q     <= exc_out_d;
        end
    end

    assign inst_ready  = inst_ready_q;
    assign issue_valid = issue_valid_q;
    assign fu_type_out = fu_type_out_q;
    assign elem_idx    = elem_idx_q;
    assign lane_en     = lane_en_q;
    assign last_group  = last_group_q;
    assign done        = done_q;
    assign exc_out     = exc_out_q;
    assign exc_idx     = exc_idx_q;

`ifdef VSEQ_PERF_CNT_EN
    logic [31:0] perf_groups_q, perf_groups_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    // Saturating counts of accepted groups and busy RUN cycles.
    always_comb begin
        perf_groups_d = perf_groups_q;
        perf_stalls_d = perf_stalls_q;
        if ((state_q == S_RUN) && !lane_busy && !flush && (perf_groups_q != 32'hFFFF_FFFF)) begin
            perf_groups_d = perf_groups_q + 32'd1;
        end
        if ((state_q == S_RUN) && lane_busy && (perf_stalls_q != 32'hFFFF_FFFF)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    // Counters clear only on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_groups_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_groups_q <= perf_groups_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_groups = perf_groups_q;
    assign perf_stalls = perf_stalls_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire
